// File: rtl/seq_alu.sv
// seq_alu: handshaked registered ALU (in_valid/in_ready -> out_valid/out_ready),
// result plus n/z/v/c/error flags; iterative MUL when SEQ_ALU_MUL_EN is defined.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             v,
  output logic             c,
  output logic             error
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FULL = 2'd1;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [1:0] BUSY = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             v_q, v_d;
  logic             c_q, c_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_r;
  logic             alu_v;
  logic             alu_c;
  logic             alu_e;
  logic             accept;

`ifdef SEQ_ALU_MUL_EN
  logic [2*WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               is_mul;
`endif

  always_comb begin
    sh    = b[SHW-1:0];
    sum   = {1'b0, a} + {1'b0, b};
    dif   = {1'b0, a} - {1'b0, b};
    alu_r = '0;
    alu_v = 1'b0;
    alu_c = 1'b0;
    alu_e = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    is_mul = 1'b0;
`endif
    unique case (opcode)
      4'b0000: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1])
              && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      4'b1000: begin
        alu_r = dif[WIDTH-1:0];
        // extended MSB of the difference is the borrow
        alu_c = dif[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1])
              && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: alu_r = a << sh;
      4'b0010: alu_r = {{(WIDTH-1){1'b0}},
                        $signed(a) > $signed(b)};
      4'b0011: alu_r = {{(WIDTH-1){1'b0}}, a > b};
      4'b0100: alu_r = a ^ b;
      4'b0101: alu_r = a >> sh;
      4'b1101: alu_r = $unsigned($signed(a) >>> sh);
      4'b0110: alu_r = a | b;
      4'b0111: alu_r = a & b;
`ifdef SEQ_ALU_MUL_EN
      4'b1001: is_mul = 1'b1;
`endif
      default: alu_e = 1'b1;
    endcase
  end

  assign in_ready = !rst
                  && ((state_q == IDLE)
                  || ((state_q == FULL) && out_ready));
  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    n_d     = n_q;
    z_d     = z_q;
    v_d     = v_q;
    c_d     = c_q;
    err_d   = err_q;
`ifdef SEQ_ALU_MUL_EN
    mc_d    = mc_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    acc_nxt = acc_q + (mb_q[0] ? mc_q : '0);
`endif
    case (state_q)
      IDLE, FULL: begin
        if ((state_q == FULL) && out_ready) begin
          state_d = IDLE;
        end
        if (accept) begin
          state_d = FULL;
          res_d   = alu_r;
          n_d     = alu_r[WIDTH-1];
          z_d     = (alu_r == '0);
          v_d     = alu_v;
          c_d     = alu_c;
          err_d   = alu_e;
`ifdef SEQ_ALU_MUL_EN
          if (is_mul) begin
            state_d = BUSY;
            mc_d    = {{WIDTH{1'b0}}, a};
            mb_d    = b;
            acc_d   = '0;
            cnt_d   = '0;
          end
`endif
        end
      end
`ifdef SEQ_ALU_MUL_EN
      BUSY: begin
        // one multiplier bit per cycle, LSB first
        acc_d = acc_nxt;
        mc_d  = mc_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = FULL;
          cnt_d   = '0;
          res_d   = acc_nxt[WIDTH-1:0];
          n_d     = acc_nxt[WIDTH-1];
          z_d     = (acc_nxt[WIDTH-1:0] == '0);
          v_d     = 1'b0;
          c_d     = |acc_nxt[2*WIDTH-1:WIDTH];
          err_d   = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mc_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      n_q     <= n_d;
      z_q     <= z_d;
      v_q     <= v_d;
      c_q     <= c_d;
      err_q   <= err_d;
`ifdef SEQ_ALU_MUL_EN
      mc_q    <= mc_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign out_valid = (state_q == FULL);
  assign result    = res_q;
  assign n         = n_q;
  assign z         = z_q;
  assign v         = v_q;
  assign c         = c_q;
  assign error     = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: bench for seq_alu, one WIDTH=32 and one WIDTH=8 instance,
// checked against an arithmetic reference model and literal vectors.
module tb_seq_alu;
`ifdef SEQ_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] r;
    logic [4:0]  f;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   acc_cyc = 0;
  int   pops [2];

  logic        iv32 = 0, or32 = 1, ir32, ov32;
  logic [31:0] a32 = 0, b32 = 0, r32;
  logic [3:0]  op32 = 0;
  logic        n32, z32, v32, c32, e32;

  logic        iv8 = 0, or8 = 1, ir8, ov8;
  logic [7:0]  a8 = 0, b8 = 0, r8;
  logic [3:0]  op8 = 0;
  logic        n8, z8, v8, c8, e8;

  exp_t q32 [$];
  exp_t q8 [$];

  logic        held [2];
  logic [63:0] hres [2];
  logic [4:0]  hflg [2];

  seq_alu #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .opcode(op32),
    .out_valid(ov32), .out_ready(or32),
    .result(r32), .n(n32), .z(z32),
    .v(v32), .c(c32), .error(e32)
  );

  seq_alu #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .opcode(op8),
    .out_valid(ov8), .out_ready(or8),
    .result(r8), .n(n8), .z(z8),
    .v(v8), .c(c8), .error(e8)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input int w,
      input logic [63:0] a, input logic [63:0] b,
      input logic [3:0] op);
    exp_t e;
    logic [63:0] mask, r;
    logic [64:0] s;
    logic [127:0] p;
    longint sa, sb;
    int sh;
    logic v, c, er;
    mask = (64'd1 << w) - 64'd1;
    sh = int'(b % 64'(w));
    sa = longint'(a);
    sb = longint'(b);
    if (a[w-1]) sa = sa - (longint'(1) << w);
    if (b[w-1]) sb = sb - (longint'(1) << w);
    r = 0; v = 0; c = 0; er = 0;
    case (op)
      4'b0000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0] & mask;
        c = s[w];
        v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      4'b1000: begin
        r = (a - b) & mask;
        c = a < b;
        v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
      4'b0001: r = (a << sh) & mask;
      4'b0010: r = (sa > sb) ? 64'd1 : 64'd0;
      4'b0011: r = (a > b) ? 64'd1 : 64'd0;
      4'b0100: r = a ^ b;
      4'b0101: r = a >> sh;
      4'b1101: r = 64'(sa >>> sh) & mask;
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b1001: begin
        if (MUL_EN) begin
          p = {64'd0, a} * {64'd0, b};
          r = p[63:0] & mask;
          c = (p >> w) != 0;
        end else begin
          er = 1;
        end
      end
      default: er = 1;
    endcase
    if (er) r = 0;
    e.r = r;
    e.f = {r[w-1], r == 0, v, c, er};
    return e;
  endfunction

  task automatic chk(input string nm,
      input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cmp_port(input int id, input logic ov,
      input logic ordy, input logic irdy,
      input logic [63:0] res, input logic [4:0] flg);
    exp_t e;
    logic got;
    if (held[id]) begin
      chk($sformatf("hold_valid%0d", id), ov, 1);
      chk($sformatf("hold_result%0d", id), res, hres[id]);
      chk($sformatf("hold_flags%0d", id), flg, hflg[id]);
    end
    if (ov && !ordy)
      chk($sformatf("stall_in_ready%0d", id), irdy, 0);
    if (ov && ordy) begin
      got = 0;
      e = '0;
      if (id == 0 && q32.size() > 0) begin
        e = q32.pop_front();
        got = 1;
      end
      if (id == 1 && q8.size() > 0) begin
        e = q8.pop_front();
        got = 1;
      end
      tests++;
      if (!got) begin
        fails++;
        $display("FAIL extra_output%0d actual=%0h required=none",
                 id, res);
      end else begin
        pops[id]++;
        chk($sformatf("model_result%0d", id), res, e.r);
        chk($sformatf("model_flags%0d", id), flg, e.f);
      end
    end
    held[id] = ov && !ordy;
    hres[id] = res;
    hflg[id] = flg;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      held[0] = 0;
      held[1] = 0;
    end else begin
      cmp_port(0, ov32, or32, ir32, 64'(r32),
               {n32, z32, v32, c32, e32});
      cmp_port(1, ov8, or8, ir8, 64'(r8),
               {n8, z8, v8, c8, e8});
    end
  end

  // caller is at posedge+1; returns at posedge+1 after the accept edge
  task automatic send(input int id, input logic [63:0] a,
      input logic [63:0] b, input logic [3:0] op);
    logic rdy;
    bit done;
    done = 0;
    if (id == 0) begin
      iv32 = 1; a32 = a[31:0]; b32 = b[31:0]; op32 = op;
    end else begin
      iv8 = 1; a8 = a[7:0]; b8 = b[7:0]; op8 = op;
    end
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      rdy = (id == 0) ? ir32 : ir8;
      @(posedge clk);
      if (rdy) done = 1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL accept_timeout%0d actual=0 required=1", id);
    end else if (id == 0) begin
      q32.push_back(model(32, {32'd0, a[31:0]},
                          {32'd0, b[31:0]}, op));
    end else begin
      q8.push_back(model(8, {56'd0, a[7:0]},
                         {56'd0, b[7:0]}, op));
    end
    #1;
    acc_cyc = cyc;
    if (id == 0) iv32 = 0;
    else iv8 = 0;
  endtask

  task automatic wait_valid(input int id, output int edges);
    bit seen;
    seen = 0;
    edges = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if ((id == 0 && ov32) || (id == 1 && ov8)) begin
        seen = 1;
        edges = cyc - acc_cyc;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL valid_timeout%0d actual=0 required=1", id);
    end
  endtask

  logic [31:0] ta [10];
  logic [31:0] tbv [10];
  logic [3:0]  top [10];

  initial begin
    int ed;
    int first;
    int cnt;
    int p0;
    ta[0] = 32'h7FFFFFFF; tbv[0] = 32'h1;        top[0] = 4'b0000;
    ta[1] = 32'h0;        tbv[1] = 32'h1;        top[1] = 4'b1000;
    ta[2] = 32'h12345678; tbv[2] = 32'h24;       top[2] = 4'b0001;
    ta[3] = 32'h80000000; tbv[3] = 32'h1F;       top[3] = 4'b0101;
    ta[4] = 32'h80000000; tbv[4] = 32'h1F;       top[4] = 4'b1101;
    ta[5] = 32'hF0F0F0F0; tbv[5] = 32'h0FF00FF0; top[5] = 4'b0100;
    ta[6] = 32'h80000000; tbv[6] = 32'h1;        top[6] = 4'b0010;
    ta[7] = 32'h80000000; tbv[7] = 32'h1;        top[7] = 4'b0011;
    ta[8] = 32'h5;        tbv[8] = 32'h7;        top[8] = 4'b1010;
    ta[9] = 32'hFFFF0000; tbv[9] = 32'h00FFFF00; top[9] = 4'b0111;
    pops[0] = 0;
    pops[1] = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {ov32, ov8}, 0);
    chk("rst_result32", r32, 0);
    chk("rst_flags32", {n32, z32, v32, c32, e32}, 0);
    chk("rst_flags8", {r8, n8, z8, v8, c8, e8}, 0);
    chk("rst_in_ready", {ir32, ir8}, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("idle_in_ready", {ir32, ir8}, 2'b11);
    @(posedge clk); #1;

    send(0, 64'hFFFFFFFF, 64'h1, 4'b0000);
    wait_valid(0, ed);
    chk("add_latency", ed, 0);
    chk("add_result", r32, 32'h0);
    chk("add_flags", {n32, z32, v32, c32, e32}, 5'b01010);
    @(posedge clk); #1;

    send(0, 64'h80000000, 64'h1, 4'b1000);
    wait_valid(0, ed);
    chk("sub_result", r32, 32'h7FFFFFFF);
    chk("sub_flags", {n32, z32, v32, c32, e32}, 5'b00100);
    @(posedge clk); #1;

    send(1, 64'h90, 64'h03, 4'b1101);
    wait_valid(1, ed);
    chk("sra8_result", r8, 8'hF2);
    chk("sra8_flags", {n8, z8, v8, c8, e8}, 5'b10000);
    @(posedge clk); #1;
    send(1, 64'hFF, 64'h01, 4'b0010);
    wait_valid(1, ed);
    chk("slt8_result", r8, 8'h00);
    @(posedge clk); #1;
    send(1, 64'hFF, 64'h01, 4'b0011);
    wait_valid(1, ed);
    chk("sltu8_result", r8, 8'h01);
    @(posedge clk); #1;

    send(1, 64'h12, 64'h34, 4'b1111);
    wait_valid(1, ed);
    chk("err_latency", ed, 0);
    chk("err_result", r8, 8'h00);
    chk("err_flags", {n8, z8, v8, c8, e8}, 5'b01001);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      send(0, {32'd0, ta[i]}, {32'd0, tbv[i]}, top[i]);
      if (i == 0) first = acc_cyc;
    end
    chk("throughput", acc_cyc - first, 9);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;

    p0 = pops[0];
    or32 = 0;
    fork
      begin
        send(0, 64'hAAAA5555, 64'h0F0F0F0F, 4'b0100);
        send(0, 64'h00FF0000, 64'h0000FF00, 4'b0110);
        send(0, 64'hFFFF00FF, 64'h0F0F0F0F, 4'b0111);
      end
      begin
        repeat (4) @(negedge clk);
        chk("bp_held_result", r32, 32'hA5A55A5A);
        @(posedge clk); #1;
        or32 = 1;
      end
    join
    repeat (4) @(negedge clk);
    chk("bp_drained", pops[0] - p0, 3);
    @(posedge clk); #1;

`ifdef SEQ_ALU_MUL_EN
    send(1, 64'h10, 64'h11, 4'b1001);
    wait_valid(1, ed);
    chk("mul_latency", ed, 8);
    chk("mul_result", r8, 8'h10);
    chk("mul_flags", {n8, z8, v8, c8, e8}, 5'b00010);
    @(posedge clk); #1;

    send(1, 64'h03, 64'h05, 4'b1001);
    @(negedge clk);
    chk("mul_busy_in_ready", ir8, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    q8.delete();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", ir8, 1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov8) cnt++;
    end
    chk("aborted_mul_outputs", cnt, 0);
    @(posedge clk); #1;
`else
    send(1, 64'h10, 64'h11, 4'b1001);
    wait_valid(1, ed);
    chk("mul_off_latency", ed, 0);
    chk("mul_off_result", r8, 8'h00);
    chk("mul_off_flags", {n8, z8, v8, c8, e8}, 5'b01001);
    @(posedge clk); #1;
`endif

    repeat (3) @(negedge clk);
    chk("q32_empty", q32.size(), 0);
    chk("q8_empty", q8.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
